shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, pipelined barrel-shift unit: the sequential successor of the single-cycle ALU shifter. It accepts one operation per cycle through a valid/ready handshake and spreads the log2(WIDTH) mux levels over STAGES register stages. It adds rotate-right, zero/negative flags, a synchronous flush and full back-pressure. It sits between the ALU operand-select logic and the writeback mux. It is selected when alufn[5:4] addresses the shift group.

## Interface
- WIDTH, 32: datapath width. Must be a power of two, 8..64.
- STAGES, 2: pipeline register stages. Range 1..$clog2(WIDTH).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline clear; highest priority after reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts the operation this cycle
- op  in  2  shift operation: 00 SHL, 01 SHR (logical), 11 SRA, 10 ROR. Same encoding as alufn[1:0].
- a  in  WIDTH  operand to shift
- b  in  WIDTH  shift amount; only b[$clog2(WIDTH)-1:0] is used
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result
- res  out  WIDTH  shifted result
- z  out  1  res == 0
- n  out  1  res[WIDTH-1]

## Operation
- Shift amount: sh = b[L-1:0], where L = $clog2(WIDTH). Upper bits of b are ignored, so an amount of 32 with WIDTH=32 behaves as 0.
- SHL: zero fill from the LSB.
- SHR: zero fill from the MSB.
- SRA: fill with a[WIDTH-1].
- ROR: bits shifted out of the LSB re-enter at the MSB.
- sh = 0 returns a unchanged for every op.
- Level j (0..L-1) shifts by 2^j when sh[j] is set. Level j is placed in stage floor(j*STAGES/L).
- Each stage register carries: valid, partial result, remaining sh bits, op.
- The fill bit for SRA is sampled from a at accept time and carried down the pipe.
- z and n are computed combinationally from the final stage register; they are not registered separately.
- Stage k advances when it is empty or stage k+1 advances. The last stage advances when out_ready is high.
- in_ready = stage-0 advance condition. It is combinational from out_ready through the valid chain; there is no skid buffer.
- Transfer occurs on valid && ready at each port.

## Timing
- Latency: exactly STAGES cycles from input accept to out_valid, with no stall.
- Throughput: 1 op/cycle while out_ready is held high.
- Reset (rst_n low, asynchronous): all valid bits go to 0 and all data registers go to 0. Resulting outputs: out_valid=0, res=0, z=1, n=0. in_ready is 1 once out of reset.
- Reset mid-operation: all in-flight operations are discarded. Nothing is replayed.
- flush high at an edge: all valid bits are cleared at that edge. Any input offered in the same cycle is dropped, and in_ready is forced to 0 during flush. Data registers keep their values. flush with an empty pipe has no effect.
- out_valid && !out_ready: res, z and n must hold stable until the transfer completes.
- Full pipe + stall: in_ready=0 and no stage changes state.
- Simultaneous output drain and input accept in a full pipe: allowed. Occupancy is unchanged.
- STAGES=1: the unit is a single registered shifter with latency 1.

## Structure
- Package shift_pkg holds:
  - enum shift_op_e {SH_SHL=2'b00, SH_SHR=2'b01, SH_ROR=2'b10, SH_SRA=2'b11}
  - function shift_level(data, op, fill, amt_bit, j) implementing one mux level
  - a function mapping level to stage
- Sub-module shift_stage: parametrised by the level range it covers. It holds the combinational levels plus its register and valid/advance logic. shift_pipe instantiates STAGES of them in a generate loop and adds the flag logic.

## Test plan
- Directed ops, WIDTH=32, STAGES=2, out_ready=1:
  - SHL 0x87654321 by 4 -> 0x76543210, z=0, n=0
  - SHR 0xFEDCBA98 by 4 -> 0x0FEDCBA9
  - SRA 0x87654321 by 4 -> 0xF8765432, n=1
  - ROR 0x87654321 by 8 -> 0x21876543
  - Each result must appear exactly 2 cycles after accept.
- Boundaries:
  - SHL 0x87654321 by 31 -> 0x80000000
  - SRA 0x87654321 by 31 -> 0xFFFFFFFF
  - SHR 0x00000001 by 1 -> 0, z=1
  - b=0x20 on any op -> a unchanged
- Back-pressure: stream 6 ops while holding out_ready low for 5 cycles mid-stream. Required: in_ready drops after 2 accepts, res stays stable while stalled, and all 6 results arrive in order with none lost or duplicated.
- Flush: with 2 ops in flight, assert flush for 1 cycle. Required: out_valid=0 on the next cycle, the flushed ops never appear, and a new op offered after flush completes with normal latency.
- Async reset: drop rst_n between clock edges with the pipe full. Required: out_valid=0, res=0, z=1 immediately, without waiting for a clock edge.
- Parameter sweep: WIDTH ∈ {8, 32, 64} × STAGES ∈ {1, L}, with random ops checked against a reference model. Required: zero mismatches and latency equal to STAGES in every configuration.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter: op encoding,
// one mux level of the shifter, and the level-to-stage placement rule.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SHL = 2'b00,
    SH_SHR = 2'b01,
    SH_ROR = 2'b10,
    SH_SRA = 2'b11
  } shift_op_e;

  // Widest datapath the helper functions handle; narrower widths are masked.
  localparam int MAX_W = 64;

  function automatic int level_stage(input int level, input int stages, input int levels);
    return (level * stages) / levels;
  endfunction

  // One mux level: shifts by 2**j when amtBit is set, otherwise passes data.
  function automatic logic [MAX_W-1:0] shift_level(
    input logic [MAX_W-1:0] data,
    input shift_op_e        op,
    input logic             fill,
    input logic             amtBit,
    input int               j,
    input int               width
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] topBits;
    logic [MAX_W-1:0] shifted;
    int               s;
    s       = 1 << j;
    mask    = (width >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << width) - MAX_W'(1));
    topBits = mask & ~(mask >> s);
    case (op)
      SH_SHL:  shifted = data << s;
      SH_SHR:  shifted = (data & mask) >> s;
      SH_SRA:  shifted = ((data & mask) >> s) | (fill ? topBits : '0);
      default: shifted = ((data & mask) >> s) | (data << (width - s));
    endcase
    return amtBit ? (shifted & mask) : data;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of shift_pipe: the mux levels mapped to stage IDX
// followed by the stage register (valid, partial result, amount, op, fill).
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int IDX    = 0,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              advance,
  input  logic              upValid,
  input  logic [WIDTH-1:0]  upData,
  input  logic [LEVELS-1:0] upSh,
  input  shift_op_e         upOp,
  input  logic              upFill,
  output logic              valid,
  output logic [WIDTH-1:0]  data,
  output logic [LEVELS-1:0] sh,
  output shift_op_e         op,
  output logic              fill
);

  logic [MAX_W-1:0] work;

  always_comb begin
    work              = '0;
    work[WIDTH-1:0]   = upData;
    for (int j = 0; j < LEVELS; j++) begin
      if (level_stage(j, STAGES, LEVELS) == IDX) begin
        work = shift_level(work, upOp, upFill, upSh[j], j, WIDTH);
      end
    end
  end

  // Flush only drops the valid bit; payload registers keep their contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      sh    <= '0;
      op    <= SH_SHL;
      fill  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (advance) begin
      valid <= upValid;
      if (upValid) begin
        data <= work[WIDTH-1:0];
        sh   <= upSh;
        op   <= upOp;
        fill <= upFill;
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SHL/SHR/SRA/ROR) with valid/ready flow control,
// synchronous flush and zero/negative flags on the result.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             z,
  output logic             n
);

  localparam int L = $clog2(WIDTH);

  // Handshake: a transfer happens at a rising edge when valid && ready are
  // both high on that port. in_ready is combinational from out_ready through
  // the stage valid chain (no skid buffer), and is held low during flush.
  // out_valid/res never change while out_valid is high and out_ready is low.

  logic             stValid [STAGES];
  logic [WIDTH-1:0] stData  [STAGES];
  logic [L-1:0]     stSh    [STAGES];
  shift_op_e        stOp    [STAGES];
  logic             stFill  [STAGES];
  logic             advance [STAGES];

  // A stage moves when it is empty or the stage after it moves.
  always_comb begin : advChain
    logic down;
    down = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      advance[k] = !stValid[k] || down;
      down       = advance[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    logic             upValid;
    logic [WIDTH-1:0] upData;
    logic [L-1:0]     upSh;
    shift_op_e        upOp;
    logic             upFill;

    if (k == 0) begin : gHead
      assign upValid = in_valid && !flush;
      assign upData  = a;
      assign upSh    = b[L-1:0];
      assign upOp    = shift_op_e'(op);
      assign upFill  = a[WIDTH-1];
    end else begin : gBody
      assign upValid = stValid[k-1];
      assign upData  = stData[k-1];
      assign upSh    = stSh[k-1];
      assign upOp    = stOp[k-1];
      assign upFill  = stFill[k-1];
    end

    shift_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k),
      .LEVELS (L)
    ) uStage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .advance (advance[k]),
      .upValid (upValid),
      .upData  (upData),
      .upSh    (upSh),
      .upOp    (upOp),
      .upFill  (upFill),
      .valid   (stValid[k]),
      .data    (stData[k]),
      .sh      (stSh[k]),
      .op      (stOp[k]),
      .fill    (stFill[k])
    );
  end

  assign in_ready  = advance[0] && !flush;
  assign out_valid = stValid[STAGES-1];
  assign res       = stData[STAGES-1];
  assign z         = (res == '0);
  assign n         = res[WIDTH-1];

  // Control fields of the last stage and upper amount bits have no consumer.
  logic unusedTail;
  assign unusedTail = ^{stSh[STAGES-1], stOp[STAGES-1], stFill[STAGES-1], b[WIDTH-1:L]};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: main 32-bit/2-stage instance plus an
// 8-bit/3-stage and a 64-bit/1-stage instance for latency and width corners.
module tb_shift_pipe;
  import shift_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (WIDTH=32, STAGES=2) ----------------
  logic        flush, inValid, inReady, outValid, outReady, z, n;
  logic [1:0]  opIn;
  logic [31:0] aIn, bIn, res;

  shift_pipe #(.WIDTH(32), .STAGES(2)) uDut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(inValid), .in_ready(inReady),
    .op(opIn), .a(aIn), .b(bIn), .out_valid(outValid), .out_ready(outReady),
    .res(res), .z(z), .n(n)
  );

  // ---------------- WIDTH=8, STAGES=3 ----------------
  logic       flush8, inValid8, inReady8, outValid8, outReady8, z8, n8;
  logic [1:0] op8;
  logic [7:0] a8, b8, res8;

  shift_pipe #(.WIDTH(8), .STAGES(3)) uDut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(inValid8), .in_ready(inReady8),
    .op(op8), .a(a8), .b(b8), .out_valid(outValid8), .out_ready(outReady8),
    .res(res8), .z(z8), .n(n8)
  );

  // ---------------- WIDTH=64, STAGES=1 ----------------
  logic        flush64, inValid64, inReady64, outValid64, outReady64, z64, n64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, res64;

  shift_pipe #(.WIDTH(64), .STAGES(1)) uDut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64), .in_valid(inValid64), .in_ready(inReady64),
    .op(op64), .a(a64), .b(b64), .out_valid(outValid64), .out_ready(outReady64),
    .res(res64), .z(z64), .n(n64)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  bit          sbOn = 1'b0;
  int          pushCnt = 0;
  int          recvCnt = 0;
  int          acceptCnt = 0;

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n && sbOn) begin
      if (inValid && inReady) acceptCnt++;
      if (outValid && outReady) begin
        recvCnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_result", 64'(res), 64'(e));
        end else begin
          check("sb_extra_result", 64'(recvCnt), 64'(pushCnt));
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic send(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    bit rdy;
    int guard;
    inValid = 1'b1; opIn = o; aIn = av; bIn = bv;
    guard = 0;
    do begin
      @(negedge clk);
      rdy = inReady;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 50);
    check("send_ready", 64'(rdy), 64'(1));
    inValid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ev,
                          input logic ez, input logic en);
    send(o, av, bv);
    @(negedge clk);
    check({tag, "_early"}, 64'(outValid), 64'(0));
    @(negedge clk);
    check({tag, "_valid"}, 64'(outValid), 64'(1));
    check(tag, 64'(res), 64'(ev));
    check({tag, "_z"}, 64'(z), 64'(ez));
    check({tag, "_n"}, 64'(n), 64'(en));
    @(posedge clk); #1;
  endtask

  task automatic runSmall(input string tag, input bit wide, input logic [1:0] o,
                          input logic [63:0] av, input logic [63:0] bv, input logic [63:0] ev);
    int lat;
    int expLat;
    expLat = wide ? 1 : 3;
    if (wide) begin
      inValid64 = 1'b1; op64 = o; a64 = av; b64 = bv;
    end else begin
      inValid8 = 1'b1; op8 = o; a8 = av[7:0]; b8 = bv[7:0];
    end
    @(negedge clk);
    check({tag, "_ready"}, 64'(wide ? inReady64 : inReady8), 64'(1));
    @(posedge clk); #1;
    inValid8 = 1'b0; inValid64 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(wide ? outValid64 : outValid8) && lat < 10);
    check({tag, "_latency"}, 64'(lat), 64'(expLat));
    check(tag, wide ? res64 : {56'h0, res8}, ev);
    @(posedge clk); #1;
  endtask

  // ---------------- back-pressure vectors ----------------
  logic [1:0]  bpOp  [6] = '{SH_SHL, SH_SHR, SH_SRA, SH_ROR, SH_SHL, SH_SHR};
  logic [31:0] bpA   [6] = '{32'h3, 32'h8000_0000, 32'h8000_0000, 32'hF, 32'hABCD, 32'hABCD_0000};
  logic [31:0] bpB   [6] = '{32'd1, 32'd4, 32'd4, 32'd4, 32'd16, 32'd16};
  logic [31:0] bpExp [6] = '{32'h6, 32'h0800_0000, 32'hF800_0000, 32'hF000_0000,
                             32'hABCD_0000, 32'h0000_ABCD};

  // ---------------- main sequence ----------------
  initial begin : mainSeq
    int acc0;
    int r0;
    int guard;
    rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; opIn = '0; aIn = '0; bIn = '0; outReady = 1'b1;
    flush8 = 1'b0; inValid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; outReady8 = 1'b1;
    flush64 = 1'b0; inValid64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; outReady64 = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 64'(outValid), 64'(0));
    check("rst_res", 64'(res), 64'(0));
    check("rst_z", 64'(z), 64'(1));
    check("rst_n_flag", 64'(n), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(inReady), 64'(1));

    // Directed ops and boundaries
    directed("shl4",  SH_SHL, 32'h8765_4321, 32'd4,  32'h7654_3210, 1'b0, 1'b0);
    directed("shr4",  SH_SHR, 32'hFEDC_BA98, 32'd4,  32'h0FED_CBA9, 1'b0, 1'b0);
    directed("sra4",  SH_SRA, 32'h8765_4321, 32'd4,  32'hF876_5432, 1'b0, 1'b1);
    directed("ror8",  SH_ROR, 32'h8765_4321, 32'd8,  32'h2187_6543, 1'b0, 1'b0);
    directed("shl31", SH_SHL, 32'h8765_4321, 32'd31, 32'h8000_0000, 1'b0, 1'b1);
    directed("sra31", SH_SRA, 32'h8765_4321, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b1);
    directed("shr1",  SH_SHR, 32'h0000_0001, 32'd1,  32'h0000_0000, 1'b1, 1'b0);
    directed("shl_hi_b", SH_SHL, 32'h8765_4321, 32'h24, 32'h7654_3210, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      directed("b32", 2'(i), 32'h8765_4321, 32'h20, 32'h8765_4321, 1'b0, 1'b1);

    // Back-pressure: out_ready low for 5 cycles while 6 ops stream in
    sbOn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(bpExp[i]);
      pushCnt++;
    end
    r0 = recvCnt;
    acc0 = acceptCnt;
    outReady = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(bpOp[i], bpA[i], bpB[i]);
      end
      begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_in_ready", 64'(inReady), 64'(0));
          check("bp_res_hold", 64'(res), 64'h6);
          check("bp_accepts", 64'(acceptCnt - acc0), 64'(2));
        end
        @(posedge clk); #1;
        outReady = 1'b1;
      end
    join
    guard = 0;
    while ((recvCnt - r0) < 6 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("bp_count", 64'(recvCnt - r0), 64'(6));
    check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // Flush with two ops in flight and an op offered during flush
    outReady = 1'b0;
    send(SH_SHL, 32'h1, 32'd1);
    send(SH_SHL, 32'h2, 32'd1);
    flush = 1'b1; inValid = 1'b1; opIn = SH_SHL; aIn = 32'h7; bIn = 32'd1;
    @(negedge clk);
    check("flush_in_ready", 64'(inReady), 64'(0));
    check("flush_pre_valid", 64'(outValid), 64'(1));
    @(posedge clk); #1;
    flush = 1'b0; inValid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(outValid), 64'(0));
    repeat (2) @(negedge clk);
    check("flush_stays_empty", 64'(outValid), 64'(0));
    @(posedge clk); #1;
    outReady = 1'b1;
    exp_q.push_back(32'h14);
    pushCnt++;
    directed("flush_after", SH_SHL, 32'h5, 32'd2, 32'h14, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("flush_queue_empty", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset with a full pipe
    sbOn = 1'b0;
    outReady = 1'b0;
    send(SH_SRA, 32'h8000_0000, 32'd4);
    send(SH_SHL, 32'h1234_5678, 32'd0);
    check("arst_pre_valid", 64'(outValid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(outValid), 64'(0));
    check("arst_res", 64'(res), 64'(0));
    check("arst_z", 64'(z), 64'(1));
    check("arst_n_flag", 64'(n), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    check("arst_no_replay", 64'(outValid), 64'(0));
    @(posedge clk); #1;
    directed("post_reset", SH_ROR, 32'h8765_4321, 32'd8, 32'h2187_6543, 1'b0, 1'b0);

    // WIDTH=8 / STAGES=3
    runSmall("w8_shl", 1'b0, SH_SHL, 64'h96, 64'd3, 64'hB0);
    runSmall("w8_shr", 1'b0, SH_SHR, 64'h96, 64'd3, 64'h12);
    runSmall("w8_sra", 1'b0, SH_SRA, 64'h96, 64'd3, 64'hF2);
    runSmall("w8_ror", 1'b0, SH_ROR, 64'h96, 64'd3, 64'hD2);
    runSmall("w8_b8",  1'b0, SH_SRA, 64'h96, 64'd8, 64'h96);

    // WIDTH=64 / STAGES=1
    runSmall("w64_shl",   1'b1, SH_SHL, 64'h0123_4567_89AB_CDEF, 64'd4,  64'h1234_5678_9ABC_DEF0);
    runSmall("w64_ror",   1'b1, SH_ROR, 64'h0123_4567_89AB_CDEF, 64'd8,  64'hEF01_2345_6789_ABCD);
    runSmall("w64_sra63", 1'b1, SH_SRA, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF);
    runSmall("w64_shr63", 1'b1, SH_SHR, 64'h8000_0000_0000_0000, 64'd63, 64'h1);
    runSmall("w64_b64",   1'b1, SH_ROR, 64'h0123_4567_89AB_CDEF, 64'h40, 64'h0123_4567_89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
